dsc_mul_nway: RTL and testbench

Parametrised deterministic stochastic-computing (DSC) multiplier. It multiplies NUM_INPUTS unsigned NUM_BITS-bit operands exactly, using clock-division unary streams generated from a single clock. It is the generalised successor of the fixed 4-input/4-bit `dsc_mul`, and adds three things: a start/busy/done handshake, an on-chip RUN-cycle counter, and optional early termination once no further ones can occur. It sits between the binary operand registers and the stoch-to-bin result path in the serial DSC datapath.

---
 rtl/dsc_mul_nway.sv | 138 +++++++++++++
 tb/tb_dsc_mul_nway.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_nway.sv
// Deterministic stochastic-computing multiplier: N unsigned W-bit operands are
// multiplied exactly by counting coincident ones of clock-division unary streams.
`timescale 1ns/1ps
module dsc_mul_nway #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_BITS   = 4,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic [NUM_INPUTS*NUM_BITS-1:0]   i_ops,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [NUM_INPUTS*NUM_BITS-1:0]   o_z,
  output logic [NUM_INPUTS*NUM_BITS:0]     o_cyc
);

  localparam int N  = NUM_INPUTS;
  localparam int W  = NUM_BITS;
  localparam int ZW = N * W;
  localparam int CW = ZW + 1;

  localparam logic [W-1:0] CTR_MAX = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_op  [N];
  logic [W-1:0]  r_ctr [N];
  logic [ZW-1:0] r_z;
  logic [CW-1:0] r_cyc;
  logic          r_busy;
  logic          r_done;

  logic [N-1:0]  w_s;
  logic [N-1:0]  w_at_max;
  logic [N-1:0]  w_en;
  logic          w_p;
  logic          w_any_zero;
  logic          w_low_full;
  logic          w_term;
  logic [W-1:0]  w_top_last;

  always_comb begin
    w_any_zero = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_ops[k*W +: W] == '0) w_any_zero = 1'b1;
    end
  end

  always_comb begin
    w_s      = '0;
    w_at_max = '0;
    for (int k = 0; k < N; k++) begin
      w_s[k]      = (r_op[k] > r_ctr[k]);
      w_at_max[k] = (r_ctr[k] == CTR_MAX);
    end
  end

  // Ripple enable: counter k steps only when every lower counter is at its max.
  always_comb begin : en_chain
    logic en;
    w_en = '0;
    for (int k = 0; k < N; k++) begin
      en = 1'b1;
      for (int j = 0; j < k; j++) en = en & w_at_max[j];
      w_en[k] = en;
    end
  end

  assign w_p        = &w_s;
  assign w_low_full = w_en[N-1];
  assign w_top_last = r_op[N-1] - W'(1);

  // Early exit: once the top counter reaches op-1 no later cycle can yield a one.
  assign w_term = EARLY_TERM ? (w_low_full && (r_ctr[N-1] == w_top_last))
                             : (w_low_full && w_at_max[N-1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_z     <= '0;
      r_cyc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_op[k]  <= '0;
        r_ctr[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int k = 0; k < N; k++) begin
              r_op[k]  <= i_ops[k*W +: W];
              r_ctr[k] <= '0;
            end
            r_z    <= '0;
            r_cyc  <= '0;
            r_busy <= 1'b1;
            r_done <= w_any_zero;
            r_state <= w_any_zero ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_z   <= r_z + ZW'(w_p);
          r_cyc <= r_cyc + CW'(1);
          for (int k = 0; k < N; k++) begin
            r_ctr[k] <= r_ctr[k] + W'(w_en[k]);
          end
          if (w_term) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_z    = r_z;
  assign o_cyc  = r_cyc;

endmodule

// File: tb/tb_dsc_mul_nway.sv
// Scoreboard bench for dsc_mul_nway: three instances (N=2 full run, N=2 early
// exit, N=4 early exit) driven by directed vectors, checked on each done pulse.
`timescale 1ns/1ps
module tb_dsc_mul_nway;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_start, a_busy, a_done;
  logic [7:0]  a_ops, a_z;
  logic [8:0]  a_cyc;
  logic        b_start, b_busy, b_done;
  logic [7:0]  b_ops, b_z;
  logic [8:0]  b_cyc;
  logic        c_start, c_busy, c_done;
  logic [15:0] c_ops, c_z;
  logic [16:0] c_cyc;

  dsc_mul_nway #(.NUM_INPUTS(2), .NUM_BITS(4), .EARLY_TERM(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_ops(a_ops),
    .o_busy(a_busy), .o_done(a_done), .o_z(a_z), .o_cyc(a_cyc));

  dsc_mul_nway #(.NUM_INPUTS(2), .NUM_BITS(4), .EARLY_TERM(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_ops(b_ops),
    .o_busy(b_busy), .o_done(b_done), .o_z(b_z), .o_cyc(b_cyc));

  dsc_mul_nway #(.NUM_INPUTS(4), .NUM_BITS(4), .EARLY_TERM(1'b1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(c_start), .i_ops(c_ops),
    .o_busy(c_busy), .o_done(c_done), .o_z(c_z), .o_cyc(c_cyc));

  typedef struct {
    longint z;
    longint cyc;
    longint t0;
  } exp_t;

  exp_t   q [3][$];
  int     done_n [3];
  logic   prev_d [3];
  int     checks = 0;
  int     fails  = 0;
  longint cnt    = 0;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  task automatic mon(input int i, input logic d, input logic b, input longint zv, input longint cv);
    exp_t e;
    if (d) begin
      done_n[i]++;
      check($sformatf("dut%0d_done_single_pulse", i), longint'(prev_d[i]), 0);
      check($sformatf("dut%0d_busy_at_done", i), longint'(b), 1);
      if (q[i].size() == 0) begin
        check($sformatf("dut%0d_unexpected_done", i), 1, 0);
      end else begin
        e = q[i].pop_front();
        check($sformatf("dut%0d_z", i), zv, e.z);
        check($sformatf("dut%0d_cyc", i), cv, e.cyc);
        check($sformatf("dut%0d_latency", i), cnt - e.t0, e.cyc + 1);
      end
    end
    prev_d[i] = d;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      done_n[i] = 0;
      prev_d[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      mon(0, a_done, a_busy, longint'(a_z), longint'(a_cyc));
      mon(1, b_done, b_busy, longint'(b_z), longint'(b_cyc));
      mon(2, c_done, c_busy, longint'(c_z), longint'(c_cyc));
    end
  end

  task automatic drive(input int i, input longint ops, input logic st);
    case (i)
      0:       begin a_ops = ops[7:0];  a_start = st; end
      1:       begin b_ops = ops[7:0];  b_start = st; end
      default: begin c_ops = ops[15:0]; c_start = st; end
    endcase
  endtask

  // One-cycle start pulse; returns at the negedge right after the accepting edge.
  task automatic issue(input int i, input longint ops, input longint ez, input longint ecyc, input bit push);
    @(negedge clk);
    drive(i, ops, 1'b1);
    if (push) q[i].push_back('{ez, ecyc, cnt});
    @(negedge clk);
    drive(i, ops, 1'b0);
  endtask

  task automatic wait_done(input int i, input int target, input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done_n[i] >= target) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check($sformatf("dut%0d_done_timeout", i), 0, 1);
  endtask

  task automatic run(input int i, input longint ops, input longint ez, input longint ecyc);
    int n;
    n = done_n[i];
    issue(i, ops, ez, ecyc, 1'b1);
    wait_done(i, n + 1, int'(ecyc) + 20);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  found;
    longint d0;
    a_start = 1'b0; a_ops = '0;
    b_start = 1'b0; b_ops = '0;
    c_start = 1'b0; c_ops = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  longint'(a_busy), 0);
    check("rst_done",  longint'(a_done), 0);
    check("rst_z",     longint'(c_z), 0);
    check("rst_cyc",   longint'(c_cyc), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", longint'(b_busy), 0);
    check("idle_z",    longint'(b_z), 0);

    // Full-length runs, N=2
    run(0, 'hFF, 225, 256);
    run(0, 'h97,  63, 256);
    run(0, 'h50,   0,   0);

    // Early termination, N=2
    run(1, 'h97,  63, 144);
    run(1, 'hFF, 225, 240);
    run(1, 'h1F,  15,  16);
    run(1, 'h0F,   0,   0);

    // Mid-run start pulse and operand change are ignored
    n = done_n[0];
    issue(0, 'h53, 15, 256, 1'b1);
    repeat (10) @(negedge clk);
    drive(0, 'hFF, 1'b1);
    @(negedge clk);
    drive(0, 'h00, 1'b0);
    wait_done(0, n + 1, 300);

    // Asynchronous reset in the middle of a run
    issue(0, 'h99, 0, 0, 1'b0);
    repeat (50) @(negedge clk);
    check("midrun_z",    longint'(a_z), 29);
    check("midrun_cyc",  longint'(a_cyc), 50);
    check("midrun_busy", longint'(a_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", longint'(a_busy), 0);
    check("async_rst_done", longint'(a_done), 0);
    check("async_rst_z",    longint'(a_z), 0);
    check("async_rst_cyc",  longint'(a_cyc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", longint'(a_busy), 0);
    run(0, 'h99, 81, 256);

    // Back-to-back with start held high
    n = done_n[1];
    @(negedge clk);
    drive(1, 'h23, 1'b1);
    q[1].push_back('{6, 32, cnt});
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (b_done) begin
        found = 1'b1;
        break;
      end
    end
    check("b2b_first_done_seen", longint'(found), 1);
    if (found) begin
      d0 = cnt;
      drive(1, 'h35, 1'b1);
      q[1].push_back('{15, 48, d0 + 1});
      @(negedge clk);
      check("b2b_gap_busy", longint'(b_busy), 0);
      check("b2b_gap_done", longint'(b_done), 0);
      check("b2b_hold_z",   longint'(b_z), 6);
      @(negedge clk);
      check("b2b_second_busy", longint'(b_busy), 1);
      drive(1, 'h35, 1'b0);
      wait_done(1, n + 2, 80);
    end else begin
      drive(1, 'h00, 1'b0);
    end

    // N=4, early termination
    run(2, 'h3F0F,     0,     0);
    run(2, 'h1357,   105,  4096);
    run(2, 'h2FED,  5460,  8192);
    run(2, 'hFFFF, 50625, 61440);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d_scoreboard_drained", i), longint'(q[i].size()), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
